// File: rtl/a_format_decoder_if.sv
// Bundle between the predecoder and the A-form decoder.
// The master side issues instructions. The slave side returns the registered decode.
interface a_format_decoder_if #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3,
    parameter int PrimOpcodeSize          = 6
);
    logic                               enable_i;
    logic                               stall_i;
    logic [24:0]                        instFormat_i;
    logic [PrimOpcodeSize-1:0]          instructionOpcode_i;
    logic [instructionWidth-1:0]        instruction_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic                               is64Bit_i;
    logic [PidSize-1:0]                 instructionPid_i;
    logic [TidSize-1:0]                 instructionTid_i;
    logic [instructionCounterWidth-1:0] instructionMajId_i;

    logic                               enable_o;
    logic [opcodeSize-1:0]              opcode_o;
    logic [funcUnitCodeSize-1:0]        functionalUnitType_o;
    logic [addressWidth-1:0]            instructionAddress_o;
    logic                               is64Bit_o;
    logic [PidSize-1:0]                 instPid_o;
    logic [TidSize-1:0]                 instTid_o;
    logic [instructionCounterWidth-1:0] instMajId_o;
    logic [instMinIdWidth-1:0]          instMinId_o;
    logic [instMinIdWidth-1:0]          numMicroOps_o;
    logic [regAccessPatternSize-1:0]    op1rw_o, op2rw_o, op3rw_o, op4rw_o;
    logic                               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
    logic                               modifiesCR_o;
    logic [20:0]                        instructionBody_o;

    modport master (
        output enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
               instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
               instructionMajId_i,
        input  enable_o, opcode_o, functionalUnitType_o, instructionAddress_o, is64Bit_o,
               instPid_o, instTid_o, instMajId_o, instMinId_o, numMicroOps_o,
               op1rw_o, op2rw_o, op3rw_o, op4rw_o,
               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
               modifiesCR_o, instructionBody_o
    );

    modport slave (
        input  enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
               instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
               instructionMajId_i,
        output enable_o, opcode_o, functionalUnitType_o, instructionAddress_o, is64Bit_o,
               instPid_o, instTid_o, instMajId_o, instMinId_o, numMicroOps_o,
               op1rw_o, op2rw_o, op3rw_o, op4rw_o,
               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
               modifiesCR_o, instructionBody_o
    );
endinterface

// File: rtl/a_format_decoder.sv
// A-form instruction decoder: isel plus the 59/63 floating-point arithmetic group.
// Instruction bit 0 is the MSB, so PowerPC bit k maps to instruction_i[31-k].
module a_format_decoder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regSize                 = 5,
    parameter int regAccessPatternSize    = 2,
    parameter int funcUnitCodeSize        = 3,
    parameter logic [1:0] regRead         = 2'b10,
    parameter logic [1:0] regWrite        = 2'b01,
    parameter int FXUnitId                = 0,
    parameter int FPUnitId                = 1,
    parameter int A                       = 2,
    parameter int PrimOpcodeSize          = 6
) (
    input logic                 clock_i,
    input logic                 reset_i,
    a_format_decoder_if.slave   bus
);
    localparam logic [regAccessPatternSize-1:0] noAccess = '0;

    logic [4:0]                             xoP0;
    logic                                   rcP0;
    logic [regSize-1:0]                     raP0;
    logic                                   acceptP0;
    logic                                   validP0;
    logic                                   modifiesCrP0;
    logic [funcUnitCodeSize-1:0]            unitP0;
    logic [regAccessPatternSize-1:0]        op2RwP0, op3RwP0, op4RwP0;
    logic                                   op2RegP0, op3RegP0, op4RegP0;

    assign xoP0     = bus.instruction_i[5:1];
    assign rcP0     = bus.instruction_i[0];
    assign raP0     = bus.instruction_i[20:16];
    assign acceptP0 = bus.enable_i && !bus.stall_i && (bus.instFormat_i == 25'(A));

    // Stage p0: combinational classification of the incoming instruction
    always_comb begin
        validP0      = 1'b0;
        unitP0       = funcUnitCodeSize'(FPUnitId);
        modifiesCrP0 = rcP0;
        op2RwP0      = noAccess;
        op3RwP0      = noAccess;
        op4RwP0      = noAccess;
        op2RegP0     = 1'b0;
        op3RegP0     = 1'b0;
        op4RegP0     = 1'b0;
        case (bus.instructionOpcode_i)
            6'd31: begin
                if (xoP0 == 5'd15) begin
                    validP0      = 1'b1;
                    unitP0       = funcUnitCodeSize'(FXUnitId);
                    modifiesCrP0 = 1'b0;
                    // RA=0 selects a literal zero rather than GPR0
                    if (raP0 != '0) begin
                        op2RwP0  = regRead;
                        op2RegP0 = 1'b1;
                    end
                    op3RwP0  = regRead;
                    op3RegP0 = 1'b1;
                    op4RwP0  = regRead;
                end
            end
            6'd59, 6'd63: begin
                case (xoP0)
                    5'd18, 5'd20, 5'd21: begin
                        validP0  = 1'b1;
                        op2RwP0  = regRead;  op2RegP0 = 1'b1;
                        op3RwP0  = regRead;  op3RegP0 = 1'b1;
                    end
                    5'd22, 5'd24, 5'd26: begin
                        validP0  = 1'b1;
                        op3RwP0  = regRead;  op3RegP0 = 1'b1;
                    end
                    5'd25: begin
                        validP0  = 1'b1;
                        op2RwP0  = regRead;  op2RegP0 = 1'b1;
                        op4RwP0  = regRead;  op4RegP0 = 1'b1;
                    end
                    5'd23, 5'd28, 5'd29, 5'd30, 5'd31: begin
                        // fsel exists only in the double-precision group
                        if (xoP0 != 5'd23 || bus.instructionOpcode_i == 6'd63) begin
                            validP0  = 1'b1;
                            op2RwP0  = regRead;  op2RegP0 = 1'b1;
                            op3RwP0  = regRead;  op3RegP0 = 1'b1;
                            op4RwP0  = regRead;  op4RegP0 = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Stage p1: registered outputs; stall freezes everything, payload only moves on a decode
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            bus.enable_o             <= 1'b0;
            bus.opcode_o             <= '0;
            bus.functionalUnitType_o <= '0;
            bus.instructionAddress_o <= '0;
            bus.is64Bit_o            <= 1'b0;
            bus.instPid_o            <= '0;
            bus.instTid_o            <= '0;
            bus.instMajId_o          <= '0;
            bus.instMinId_o          <= '0;
            bus.numMicroOps_o        <= '0;
            bus.op1rw_o              <= '0;
            bus.op2rw_o              <= '0;
            bus.op3rw_o              <= '0;
            bus.op4rw_o              <= '0;
            bus.op1IsReg_o           <= 1'b0;
            bus.op2IsReg_o           <= 1'b0;
            bus.op3IsReg_o           <= 1'b0;
            bus.op4IsReg_o           <= 1'b0;
            bus.modifiesCR_o         <= 1'b0;
            bus.instructionBody_o    <= '0;
        end else if (!bus.stall_i) begin
            bus.enable_o <= acceptP0 && validP0;
            if (acceptP0 && validP0) begin
                bus.opcode_o             <= {bus.instructionOpcode_i, xoP0, rcP0};
                bus.functionalUnitType_o <= unitP0;
                bus.instructionAddress_o <= bus.instructionAddress_i;
                bus.is64Bit_o            <= bus.is64Bit_i;
                bus.instPid_o            <= bus.instructionPid_i;
                bus.instTid_o            <= bus.instructionTid_i;
                bus.instMajId_o          <= bus.instructionMajId_i;
                bus.instMinId_o          <= '0;
                bus.numMicroOps_o        <= '0;
                bus.op1rw_o              <= regWrite;
                bus.op2rw_o              <= op2RwP0;
                bus.op3rw_o              <= op3RwP0;
                bus.op4rw_o              <= op4RwP0;
                bus.op1IsReg_o           <= 1'b1;
                bus.op2IsReg_o           <= op2RegP0;
                bus.op3IsReg_o           <= op3RegP0;
                bus.op4IsReg_o           <= op4RegP0;
                bus.modifiesCR_o         <= modifiesCrP0;
                bus.instructionBody_o    <= {bus.instruction_i[25:6], rcP0};
            end
        end
    end
endmodule

// File: tb/tb_a_format_decoder.sv
// Scoreboard bench for a_format_decoder: expected decodes are queued at drive time
// and popped when the decoder presents them one cycle later.
module tb_a_format_decoder;
    localparam logic [24:0] aFormat = 25'd2;

    typedef struct packed {
        logic [11:0] opcode;
        logic [2:0]  unit;
        logic [7:0]  rw;       // {op1,op2,op3,op4}
        logic [3:0]  isReg;    // {op1,op2,op3,op4}
        logic        modCr;
        logic [20:0] body;
        logic [63:0] addr;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [63:0] maj;
    } expT;

    logic clk = 1'b0;
    logic rstN = 1'b1;
    int   nVec = 0;
    int   nFail = 0;
    expT  sb[$];
    expT  held = '0;
    logic prevEn = 1'b0;
    int   pulses31 = 0, pulses59 = 0, pulses63 = 0;

    a_format_decoder_if bus ();

    a_format_decoder dut (
        .clock_i (clk),
        .reset_i (rstN),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nVec++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkInst(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] ra, input logic [4:0] rb,
                                           input logic [4:0] rc5, input logic [4:0] xo,
                                           input logic rc);
        return {op, rt, ra, rb, rc5, xo, rc};
    endfunction

    // Reference decode, organised by which operands each XO touches
    function automatic logic model(input logic [5:0] op, input logic [31:0] instr, output expT e);
        logic [4:0] xo;
        logic rc, v, u2, u3, u4;
        xo = instr[5:1];
        rc = instr[0];
        e = '0;
        e.opcode = {op, xo, rc};
        e.body   = {instr[25:6], rc};
        v = 1'b0;
        if (op == 6'd31 && xo == 5'd15) begin
            v = 1'b1;
            e.unit  = 3'd0;
            e.modCr = 1'b0;
            e.rw    = {2'b01, (instr[20:16] != 5'd0) ? 2'b10 : 2'b00, 2'b10, 2'b10};
            e.isReg = {1'b1, instr[20:16] != 5'd0, 1'b1, 1'b0};
        end else if (op == 6'd59 || op == 6'd63) begin
            v = (xo inside {18, [20:22], [24:26], [28:31]}) || (op == 6'd63 && xo == 5'd23);
            u2 = xo inside {18, 20, 21, 23, 25, [28:31]};
            u3 = xo inside {18, 20, 21, 22, 23, 24, 26, [28:31]};
            u4 = xo inside {23, 25, [28:31]};
            e.unit  = 3'd1;
            e.modCr = rc;
            e.rw    = {2'b01, u2 ? 2'b10 : 2'b00, u3 ? 2'b10 : 2'b00, u4 ? 2'b10 : 2'b00};
            e.isReg = {1'b1, u2, u3, u4};
        end
        return v;
    endfunction

    task automatic checkOutputs(input expT h);
        checkVal("opcode_o", 256'(bus.opcode_o), 256'(h.opcode));
        checkVal("functionalUnitType_o", 256'(bus.functionalUnitType_o), 256'(h.unit));
        checkVal("oprw", 256'({bus.op1rw_o, bus.op2rw_o, bus.op3rw_o, bus.op4rw_o}), 256'(h.rw));
        checkVal("opIsReg", 256'({bus.op1IsReg_o, bus.op2IsReg_o, bus.op3IsReg_o, bus.op4IsReg_o}),
                 256'(h.isReg));
        checkVal("modifiesCR_o", 256'(bus.modifiesCR_o), 256'(h.modCr));
        checkVal("instructionBody_o", 256'(bus.instructionBody_o), 256'(h.body));
        checkVal("sideband", 256'({bus.instructionAddress_o, bus.is64Bit_o, bus.instPid_o,
                                    bus.instTid_o, bus.instMajId_o}),
                 256'({h.addr, h.is64, h.pid, h.tid, h.maj}));
        checkVal("microOps", 256'({bus.instMinId_o, bus.numMicroOps_o}), 256'(0));
    endtask

    task automatic drive(input logic en, input logic st, input logic [24:0] fmt,
                         input logic [5:0] op, input logic [31:0] instr);
        expT  e;
        logic v, expEn;
        bus.enable_i             = en;
        bus.stall_i              = st;
        bus.instFormat_i         = fmt;
        bus.instructionOpcode_i  = op;
        bus.instruction_i        = instr;
        bus.instructionAddress_i = {$urandom, $urandom};
        bus.is64Bit_i            = 1'($urandom);
        bus.instructionPid_i     = 20'($urandom);
        bus.instructionTid_i     = 16'($urandom);
        bus.instructionMajId_i   = {$urandom, $urandom};
        v = model(op, instr, e);
        e.addr = bus.instructionAddress_i;
        e.is64 = bus.is64Bit_i;
        e.pid  = bus.instructionPid_i;
        e.tid  = bus.instructionTid_i;
        e.maj  = bus.instructionMajId_i;
        if (en && !st && fmt == aFormat && v) sb.push_back(e);
        expEn = st ? prevEn : (en && fmt == aFormat && v);
        @(posedge clk);
        #1;
        checkVal("enable_o", 256'(bus.enable_o), 256'(expEn));
        if (!st && bus.enable_o === 1'b1) begin
            if (op == 6'd31) pulses31++;
            if (op == 6'd59) pulses59++;
            if (op == 6'd63) pulses63++;
        end
        if (!st && expEn) begin
            checkVal("scoreboard_has_entry", 256'(sb.size() > 0), 256'(1));
            if (sb.size() > 0) held = sb.pop_front();
        end
        checkOutputs(held);
        prevEn = expEn;
    endtask

    initial begin
        bus.enable_i = 1'b0; bus.stall_i = 1'b0; bus.instFormat_i = '0;
        bus.instructionOpcode_i = '0; bus.instruction_i = '0;
        bus.instructionAddress_i = '0; bus.is64Bit_i = 1'b0; bus.instructionPid_i = '0;
        bus.instructionTid_i = '0; bus.instructionMajId_i = '0;

        // Reset state, and reset dominating a valid enable
        #1 rstN = 1'b0;
        #2;
        checkVal("reset_enable_o", 256'(bus.enable_o), 256'(0));
        checkOutputs('0);
        bus.enable_i = 1'b1; bus.instFormat_i = aFormat; bus.instructionOpcode_i = 6'd63;
        bus.instruction_i = mkInst(6'd63, 5'd1, 5'd2, 5'd3, 5'd4, 5'd21, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_priority_enable_o", 256'(bus.enable_o), 256'(0));
        checkOutputs('0);
        @(negedge clk) rstN = 1'b1;

        // First decode after reset, plus fixed-value checks for fadd with Rc=1
        drive(1, 0, aFormat, 6'd63, mkInst(6'd63, 5'd7, 5'd8, 5'd9, 5'd10, 5'd21, 1'b1));
        checkVal("fadd_opcode_o", 256'(bus.opcode_o), 256'(12'b111111_10101_1));
        checkVal("fadd_unit", 256'(bus.functionalUnitType_o), 256'(1));
        checkVal("fadd_modifiesCR", 256'(bus.modifiesCR_o), 256'(1));
        checkVal("fadd_op4", 256'({bus.op4rw_o, bus.op4IsReg_o}), 256'(0));

        // isel with RA=0, then with a real RA
        drive(1, 0, aFormat, 6'd31, mkInst(6'd31, 5'd3, 5'd0, 5'd5, 5'd6, 5'd15, 1'b0));
        checkVal("isel_unit", 256'(bus.functionalUnitType_o), 256'(0));
        checkVal("isel_op2IsReg", 256'(bus.op2IsReg_o), 256'(0));
        checkVal("isel_op4IsReg", 256'(bus.op4IsReg_o), 256'(0));
        checkVal("isel_modifiesCR", 256'(bus.modifiesCR_o), 256'(0));
        drive(1, 0, aFormat, 6'd31, mkInst(6'd31, 5'd3, 5'd9, 5'd5, 5'd6, 5'd15, 1'b1));

        // Wrong format code, idle cycle, single-precision fsel (not in the set)
        drive(1, 0, 25'd4, 6'd59, mkInst(6'd59, 5'd1, 5'd2, 5'd3, 5'd4, 5'd21, 1'b0));
        checkVal("fmt4_enable_o", 256'(bus.enable_o), 256'(0));
        drive(0, 0, aFormat, 6'd59, mkInst(6'd59, 5'd1, 5'd2, 5'd3, 5'd4, 5'd21, 1'b0));
        drive(1, 0, aFormat, 6'd59, mkInst(6'd59, 5'd1, 5'd2, 5'd3, 5'd4, 5'd23, 1'b0));
        for (int i = 0; i < 8; i++)
            drive(1, 0, aFormat, (i % 2) ? 6'd63 : 6'd59,
                  mkInst((i % 2) ? 6'd63 : 6'd59, 5'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), 5'(5'd22 + i), 1'($urandom)));

        // Stall holds a valid decode, then an invalid one
        drive(1, 0, aFormat, 6'd59, mkInst(6'd59, 5'd11, 5'd12, 5'd13, 5'd14, 5'd25, 1'b1));
        for (int i = 0; i < 3; i++)
            drive(1, 1, aFormat, 6'd63, mkInst(6'd63, 5'd1, 5'd2, 5'd3, 5'd4, 5'd21, 1'b0));
        checkVal("stall_opcode_o", 256'(bus.opcode_o), 256'(12'b111011_11001_1));
        drive(0, 0, aFormat, 6'd0, 32'd0);
        drive(1, 1, aFormat, 6'd63, mkInst(6'd63, 5'd1, 5'd2, 5'd3, 5'd4, 5'd18, 1'b0));

        // Asynchronous reset between edges after a valid decode
        drive(1, 0, aFormat, 6'd63, mkInst(6'd63, 5'd5, 5'd6, 5'd7, 5'd8, 5'd29, 1'b1));
        #3 rstN = 1'b0;
        #1;
        checkVal("async_reset_enable_o", 256'(bus.enable_o), 256'(0));
        checkOutputs('0);
        held = '0;
        prevEn = 1'b0;
        #2 rstN = 1'b1;
        drive(1, 0, aFormat, 6'd59, mkInst(6'd59, 5'd2, 5'd4, 5'd6, 5'd8, 5'd28, 1'b0));

        // Full opcode x XO sweep with fixed operand fields
        pulses31 = 0; pulses59 = 0; pulses63 = 0;
        for (int op = 0; op < 64; op++)
            for (int xo = 0; xo < 32; xo++)
                drive(1, 0, aFormat, 6'(op),
                      mkInst(6'(op), 5'b01110, 5'b10101, 5'b01010, 5'b10001, 5'(xo), 1'b0));
        drive(0, 0, aFormat, 6'd0, 32'd0);
        checkVal("sweep_pulses_op31", 256'(pulses31), 256'(1));
        checkVal("sweep_pulses_op59", 256'(pulses59), 256'(11));
        checkVal("sweep_pulses_op63", 256'(pulses63), 256'(12));
        checkVal("sweep_pulses_total", 256'(pulses31 + pulses59 + pulses63), 256'(24));
        checkVal("scoreboard_drained", 256'(sb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule

// File: doc/a_format_decoder.md
A_FORMAT_DECODER -- requirements
Module: a_format_decoder

Interface
REQ-001 Parameters (name=default): addressWidth=64, instructionWidth=32, PidSize=20, TidSize=16, instructionCounterWidth=64, instMinIdWidth=7, opcodeSize=12, regSize=5, regAccessPatternSize=2, funcUnitCodeSize=3.
REQ-002 Encoding parameters: regRead=2'b10, regWrite=2'b01, FXUnitId=0, FPUnitId=1, A=2 (format code), PrimOpcodeSize=6.
REQ-003 clock_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_i  in  1  asynchronous, active-low reset.
REQ-005 enable_i  in  1  input instruction valid.
REQ-006 stall_i  in  1  hold all outputs.
REQ-007 instFormat_i  in  25  format code from predecoder.
REQ-008 instructionOpcode_i  in  6  primary opcode.
REQ-009 instruction_i  in  32  raw instruction, bit 0 = MSB.
REQ-010 instructionAddress_i / is64Bit_i / instructionPid_i / instructionTid_i / instructionMajId_i  in  64/1/20/16/64  sideband, passed through.
REQ-011 enable_o  out  1  decoded valid A-form instruction.
REQ-012 opcode_o  out  12  {primary opcode, XO (bits 26-30), Rc (bit 31)}.
REQ-013 functionalUnitType_o  out  3  FX or FP unit id.
REQ-014 instructionAddress_o / is64Bit_o / instPid_o / instTid_o / instMajId_o  out  64/1/20/16/64  registered copies of sideband inputs.
REQ-015 instMinId_o, numMicroOps_o  out  7 each  micro-op info.
REQ-016 op1rw_o..op4rw_o  out  2 each  {read, write} flags per operand.
REQ-017 op1IsReg_o..op4IsReg_o  out  1 each  operand is a register.
REQ-018 modifiesCR_o  out  1  instruction updates CR.
REQ-019 instructionBody_o  out  21  {instruction bits 6-25, Rc}.

Function
REQ-020 Decode is accepted only when enable_i=1, stall_i=0 and instFormat_i equals A; latency one cycle, registered outputs.
REQ-021 Valid set (24): opcode 31 XO 15 (isel); opcode 59 XO 18,20,21,22,24,25,26,28,29,30,31; opcode 63 XO 18,20,21,22,23,24,25,26,28,29,30,31.
REQ-022 On an accepted valid instruction, enable_o=1 next cycle; any other accepted or non-accepted cycle with stall_i=0 drives enable_o=0.
REQ-023 stall_i=1 holds every output, including enable_o, at its current value.
REQ-024 functionalUnitType_o = FXUnitId for isel, FPUnitId for opcodes 59/63.
REQ-025 instMinId_o=0, numMicroOps_o=0 for every instruction.
REQ-026 op1 (RT/FRT, bits 6-10): rw=regWrite, isReg=1 for all valid instructions.
REQ-027 isel: op2=RA read, isReg=1 unless RA=0 (then rw=00, isReg=0); op3=RB read, isReg=1; op4=BC read, isReg=0 (CR bit).
REQ-028 fdiv/fsub/fadd (18,20,21): op2=FRA, op3=FRB read, op4 unused.
REQ-029 fsqrt/fre/frsqrte (22,24,26): op3=FRB read; op2, op4 unused.
REQ-030 fmul (25): op2=FRA, op4=FRC read; op3 unused.
REQ-031 fsel and fused multiply-add (23,28-31): op2, op3, op4 read.
REQ-032 Unused operand: rw=00, isReg=0; used FP operands isReg=1.
REQ-033 modifiesCR_o = Rc bit for opcodes 59/63; 0 for isel.
REQ-034 Payload outputs update only on accepted valid instructions; otherwise retain last value.

Reset
REQ-035 reset_i=0 asynchronously clears every output to 0; takes priority over enable_i and stall_i.
REQ-036 First accepted instruction after reset_i deasserts decodes normally on the next rising edge.

Verification
REQ-037 Sweep opcode 0-63 x XO 0-31, operands 01110/10101/01010/10001, Rc=0, one pulse each -> exactly 24 enable_o pulses (1 for op31, 11 for op59, 12 for op63).
REQ-038 opcode 63 XO 21 Rc=1 -> enable_o=1, opcode_o={111111,10101,1}, FP unit, modifiesCR_o=1, op4rw_o=00, op4IsReg_o=0.
REQ-039 opcode 31 XO 15 with RA=0 -> FX unit, op2IsReg_o=0, op4IsReg_o=0, modifiesCR_o=0.
REQ-040 Valid instruction with instFormat_i=4 -> enable_o=0.
REQ-041 Decode opcode 59 XO 25, then stall_i=1 with new instruction -> outputs unchanged while stalled.
REQ-042 Assert reset_i=0 between clock edges after a valid decode -> all outputs 0 immediately.
